// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type and bit-reversal helper.
package fft_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = 5;
  localparam int unsigned FFT_W     = 32;

  typedef struct packed {
    logic [FFT_W-1:0] re;
    logic [FFT_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } unl_state_e;

  // Mirror of a 5-bit bin index; maps natural-order bin k to its bit-reversed frame slot.
  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] k);
    return {k[0], k[1], k[2], k[3], k[4]};
  endfunction

endpackage

// File: rtl/fft32_stream_unloader_if.sv
// Parallel frame input plus valid/ready sample stream of the FFT output unloader.
interface fft32_stream_unloader_if import fft_pkg::*; #(
  parameter int unsigned W = FFT_W
) ();

  logic                   frame_valid;
  logic                   frame_ready;
  logic [FFT_N*W-1:0]     frame_r;
  logic [FFT_N*W-1:0]     frame_i;
  logic                   m_valid;
  logic                   m_ready;
  logic [W-1:0]           m_r;
  logic [W-1:0]           m_i;
  logic [FFT_LOG2N-1:0]   m_index;
  logic                   m_last;

  // Unloader side: accepts frames, sources the sample stream.
  modport master (
    input  frame_valid, frame_r, frame_i, m_ready,
    output frame_ready, m_valid, m_r, m_i, m_index, m_last
  );

  // Peer side: frame producer and stream consumer.
  modport slave (
    output frame_valid, frame_r, frame_i, m_ready,
    input  frame_ready, m_valid, m_r, m_i, m_index, m_last
  );

endinterface

// File: rtl/fft_frame_buffer.sv
// 32-entry complex register file: whole-frame parallel load, one combinational read port.
module fft_frame_buffer import fft_pkg::*; #(
  parameter int unsigned W = FFT_W
) (
  input  logic                 clk,
  input  logic                 load,
  input  logic [FFT_N*W-1:0]   load_r,
  input  logic [FFT_N*W-1:0]   load_i,
  input  logic [FFT_LOG2N-1:0] raddr,
  output logic [W-1:0]         rd_r_c,
  output logic [W-1:0]         rd_i_c
);

  logic [W-1:0] re_q [FFT_N];
  logic [W-1:0] im_q [FFT_N];
  logic [W-1:0] re_d [FFT_N];
  logic [W-1:0] im_d [FFT_N];

  // Contents hold unless a full frame is loaded; no reset since stale data is never shown.
  always_comb begin
    for (int s = 0; s < int'(FFT_N); s++) begin
      re_d[s] = re_q[s];
      im_d[s] = im_q[s];
      if (load) begin
        re_d[s] = load_r[s*W +: W];
        im_d[s] = load_i[s*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    re_q <= re_d;
    im_q <= im_d;
  end

  assign rd_r_c = re_q[raddr];
  assign rd_i_c = im_q[raddr];

endmodule

// File: rtl/fft32_stream_unloader.sv
// Captures a parallel 32-point FFT frame and streams it out one complex sample per beat,
// optionally undoing the bit-reversed bin order.
module fft32_stream_unloader import fft_pkg::*; #(
  parameter int unsigned W      = FFT_W,
  parameter bit          BITREV = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  fft32_stream_unloader_if.master bus
);

  unl_state_e           state_q, state_d;
  logic [FFT_LOG2N-1:0] cnt_q, cnt_d;

  logic                 m_valid_c;
  logic                 last_c;
  logic                 beat_c;
  logic                 frame_ready_c;
  logic                 frame_hs_c;
  logic [FFT_LOG2N-1:0] raddr_c;
  logic [W-1:0]         rd_r_c;
  logic [W-1:0]         rd_i_c;

  // Reset gates the handshakes immediately so nothing moves while rst is held.
  assign m_valid_c     = (state_q == STREAM) && !rst;
  assign last_c        = (cnt_q == FFT_LOG2N'(FFT_N - 1));
  assign beat_c        = m_valid_c && bus.m_ready;
  assign frame_ready_c = !rst && ((state_q == IDLE) || (beat_c && last_c));
  assign frame_hs_c    = bus.frame_valid && frame_ready_c;
  assign raddr_c       = BITREV ? bitrev5(cnt_q) : cnt_q;

  fft_frame_buffer #(
    .W (W)
  ) u_buf (
    .clk    (clk),
    .load   (frame_hs_c),
    .load_r (bus.frame_r),
    .load_i (bus.frame_i),
    .raddr  (raddr_c),
    .rd_r_c (rd_r_c),
    .rd_i_c (rd_i_c)
  );

  // Next state: a frame taken on the last beat restarts the count with no idle bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (frame_hs_c) begin
          state_d = STREAM;
          cnt_d   = '0;
        end
      end
      STREAM: begin
        if (beat_c) begin
          if (last_c) begin
            cnt_d   = '0;
            state_d = frame_hs_c ? STREAM : IDLE;
          end else begin
            cnt_d = cnt_q + FFT_LOG2N'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.frame_ready = frame_ready_c;
  assign bus.m_valid     = m_valid_c;
  assign bus.m_r         = rd_r_c;
  assign bus.m_i         = rd_i_c;
  assign bus.m_index     = cnt_q;
  assign bus.m_last      = last_c;

endmodule
